// File: rtl/pcie_msi_pkg.sv
// rtl/pcie_msi_pkg.sv - shared state type, vector width and helpers for the MSI interrupt controller
package pcie_msi_pkg;

  localparam int MSI_VEC_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_BACKOFF = 2'd3
  } msi_state_t;

  function automatic logic [31:0] vec_onehot(input logic [MSI_VEC_W-1:0] vec);
    return 32'd1 << vec;
  endfunction

endpackage

// File: rtl/pcie_msi_rr_arb.sv
// rtl/pcie_msi_rr_arb.sv - combinational round-robin pick of the first request at or after a pointer
module pcie_msi_rr_arb
  import pcie_msi_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]         i_req,
  input  logic [MSI_VEC_W-1:0] i_ptr,
  output logic                 o_valid,
  output logic [MSI_VEC_W-1:0] o_idx
);

  logic [MSI_VEC_W-1:0] w_cand;

  // Walk upward from the pointer with wrap; the first set request wins
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int i = 0; i < N; i++) begin
      w_cand = MSI_VEC_W'((int'(i_ptr) + i) % N);
      if (!o_valid && i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/pcie_msi_irq_ctrl.sv
// rtl/pcie_msi_irq_ctrl.sv - PF0 MSI request controller; PCIE_MSI_RETRY_EN enables backoff/reissue on fail
module pcie_msi_irq_ctrl
  import pcie_msi_pkg::*;
#(
  parameter int MSI_COUNT    = 32,
  parameter int WAIT_TIMEOUT = 1024,
  parameter int RETRY_DELAY  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MSI_COUNT-1:0] i_irq,
  output logic                 o_irq_busy,
  output logic                 o_stat_fail,
  input  logic [3:0]           i_cfg_interrupt_msi_enable,
  input  logic [11:0]          i_cfg_interrupt_msi_mmenable,
  input  logic                 i_cfg_interrupt_msi_mask_update,
  input  logic [31:0]          i_cfg_interrupt_msi_data,
  output logic [3:0]           o_cfg_interrupt_msi_select,
  output logic [31:0]          o_cfg_interrupt_msi_int,
  output logic [31:0]          o_cfg_interrupt_msi_pending_status,
  output logic                 o_cfg_interrupt_msi_pending_status_data_enable,
  output logic [3:0]           o_cfg_interrupt_msi_pending_status_function_num,
  input  logic                 i_cfg_interrupt_msi_sent,
  input  logic                 i_cfg_interrupt_msi_fail,
  output logic [2:0]           o_cfg_interrupt_msi_attr,
  output logic                 o_cfg_interrupt_msi_tph_present,
  output logic [1:0]           o_cfg_interrupt_msi_tph_type,
  output logic [7:0]           o_cfg_interrupt_msi_tph_st_tag,
  output logic [7:0]           o_cfg_interrupt_msi_function_number
);

  localparam int         CNT_MAX    = (WAIT_TIMEOUT > RETRY_DELAY) ? WAIT_TIMEOUT : RETRY_DELAY;
  localparam int         CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [2:0] LOG2_COUNT = 3'($clog2(MSI_COUNT));

  msi_state_t           r_state;
  logic [MSI_VEC_W-1:0] r_vec;
  logic [MSI_VEC_W-1:0] r_rr;
  logic [CNT_W-1:0]     r_cnt;
  logic [31:0]          r_msi_int;
  logic                 r_stat_fail;
  logic [MSI_COUNT-1:0] r_pending;
  logic [MSI_COUNT-1:0] r_mask;
  logic                 r_busy;
  logic                 r_pend_de;

  logic [2:0]           w_log2;
  logic [MSI_VEC_W-1:0] w_alias_mask;
  logic [MSI_COUNT-1:0] w_in_range;
  logic [MSI_COUNT-1:0] w_set;
  logic [MSI_COUNT-1:0] w_clr;
  logic [MSI_COUNT-1:0] w_pending_nxt;
  logic [MSI_COUNT-1:0] w_eligible;
  logic                 w_arb_valid;
  logic [MSI_VEC_W-1:0] w_arb_idx;
  logic                 w_timeout;
  logic [MSI_VEC_W-1:0] w_rr_next;
  logic                 w_unused;

  // Host may grant fewer vectors than we have; cap at MSI_COUNT
  assign w_log2       = (i_cfg_interrupt_msi_mmenable[2:0] > LOG2_COUNT) ? LOG2_COUNT
                                                                         : i_cfg_interrupt_msi_mmenable[2:0];
  assign w_alias_mask = MSI_VEC_W'((32'd1 << w_log2) - 32'd1);
  assign w_timeout    = (r_cnt == CNT_W'(WAIT_TIMEOUT - 1));
  assign w_rr_next    = MSI_VEC_W'((int'(r_vec) + 1) % MSI_COUNT);

  // Fold requests onto the granted vector range and mark which vectors are usable
  always_comb begin
    w_set      = '0;
    w_in_range = '0;
    for (int n = 0; n < MSI_COUNT; n++) begin
      w_in_range[n] = (MSI_VEC_W'(n) <= w_alias_mask);
      if (i_irq[n]) begin
        w_set[MSI_VEC_W'(n) & w_alias_mask] = 1'b1;
      end
    end
  end

  // Pending bit of the in-flight vector retires on sent, or on fail/timeout when drops are allowed
  always_comb begin
    w_clr = '0;
    if (r_state == ST_WAIT) begin
      if (i_cfg_interrupt_msi_sent) begin
        w_clr[r_vec] = 1'b1;
      end
`ifndef PCIE_MSI_RETRY_EN
      else if (i_cfg_interrupt_msi_fail || w_timeout) begin
        w_clr[r_vec] = 1'b1;
      end
`endif
    end
  end

  assign w_pending_nxt = (r_pending & ~w_clr) | w_set;
  assign w_eligible    = r_pending & ~r_mask & w_in_range
                         & {MSI_COUNT{i_cfg_interrupt_msi_enable[0]}};

  pcie_msi_rr_arb #(.N(MSI_COUNT)) u_arb (
    .i_req   (w_eligible),
    .i_ptr   (r_rr),
    .o_valid (w_arb_valid),
    .o_idx   (w_arb_idx)
  );

  // Pending bitmap, host mask, busy flag and bitmap-change strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_mask    <= '0;
      r_busy    <= 1'b0;
      r_pend_de <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_pend_de <= (w_pending_nxt != r_pending);
      r_busy    <= (|r_pending) | (r_state != ST_IDLE);
      if (i_cfg_interrupt_msi_mask_update) begin
        r_mask <= i_cfg_interrupt_msi_data[MSI_COUNT-1:0];
      end
    end
  end

  // Issue FSM: one MSI in flight, completion tracking, timeout and optional backoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_vec       <= '0;
      r_rr        <= '0;
      r_cnt       <= '0;
      r_msi_int   <= '0;
      r_stat_fail <= 1'b0;
    end else begin
      r_stat_fail <= 1'b0;
      r_msi_int   <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_arb_valid) begin
            r_vec     <= w_arb_idx;
            r_msi_int <= vec_onehot(w_arb_idx);
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_cfg_interrupt_msi_sent) begin
            r_rr    <= w_rr_next;
            r_state <= ST_IDLE;
          end else if (i_cfg_interrupt_msi_fail || w_timeout) begin
            r_stat_fail <= 1'b1;
`ifdef PCIE_MSI_RETRY_EN
            r_cnt   <= '0;
            r_state <= ST_BACKOFF;
`else
            r_rr    <= w_rr_next;
            r_state <= ST_IDLE;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_BACKOFF: begin
          if (r_cnt == CNT_W'(RETRY_DELAY - 1)) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_irq_busy                                      = r_busy;
  assign o_stat_fail                                     = r_stat_fail;
  assign o_cfg_interrupt_msi_int                         = r_msi_int;
  assign o_cfg_interrupt_msi_pending_status              = 32'(r_pending);
  assign o_cfg_interrupt_msi_pending_status_data_enable  = r_pend_de;
  assign o_cfg_interrupt_msi_select                      = 4'd0;
  assign o_cfg_interrupt_msi_pending_status_function_num = 4'd0;
  assign o_cfg_interrupt_msi_attr                        = 3'd0;
  assign o_cfg_interrupt_msi_tph_present                 = 1'b0;
  assign o_cfg_interrupt_msi_tph_type                    = 2'd0;
  assign o_cfg_interrupt_msi_tph_st_tag                  = 8'd0;
  assign o_cfg_interrupt_msi_function_number             = 8'd0;

  // Only PF0 enable and the low vector-count field are meaningful here
  assign w_unused = &{1'b0, i_cfg_interrupt_msi_enable[3:1], i_cfg_interrupt_msi_mmenable[11:3]};

endmodule
